pw_trigger_sequencer: RTL
=========================

# pw_trigger_sequencer

Sequences a downstream trigger generator through a programmable list of up to pNUM_TRIGGERS delay/width pairs. Each pair drives one armed trigger event. The block sits in the trigger_clk domain, between the synchronized pattern-match pulse and the trigger generator. It gates which matches fire a trigger and reloads the generator's delay/width before each one. The register block programs the table and arms/disarms a sequence; completion and timeout status go back to it.

## Interface
- pTRIGGER_DELAY_WIDTH, 20, width of each delay entry.
- pTRIGGER_WIDTH_WIDTH, 17, width of each width entry.
- pNUM_TRIGGERS, 8, table depth.
- pINDEX_WIDTH, 3, log2(pNUM_TRIGGERS).
- pTIMEOUT_WIDTH, 24, watchdog counter width (used only with the macro).

Ports:
- trigger_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_wr_en  in  1  table write strobe.
- I_wr_addr  in  pINDEX_WIDTH  table entry index.
- I_wr_delay  in  pTRIGGER_DELAY_WIDTH  delay written to the entry.
- I_wr_width  in  pTRIGGER_WIDTH_WIDTH  width written to the entry.
- I_num_triggers  in  pINDEX_WIDTH+1  sequence length; legal range 1..pNUM_TRIGGERS.
- I_arm  in  1  single-cycle start pulse.
- I_disarm  in  1  single-cycle abort pulse.
- I_match_pulse  in  1  match pulse, already synchronized to trigger_clk.
- I_trigger  in  1  trigger-active level from the trigger generator.
- I_timeout  in  pTIMEOUT_WIDTH  watchdog limit, in cycles.
- O_match  out  1  gated match pulse to the trigger generator.
- O_trigger_delay  out  pTRIGGER_DELAY_WIDTH  delay presented to the generator.
- O_trigger_width  out  pTRIGGER_WIDTH_WIDTH  width presented to the generator.
- O_armed  out  1  high in any state other than IDLE.
- O_done  out  1  one-cycle pulse when the sequence completes.
- O_index  out  pINDEX_WIDTH  current entry index.
- O_timeout  out  1  sticky flag; cleared by the next accepted arm.

## Operation
- Table: pNUM_TRIGGERS registers, zeroed on reset.
  - Writes are accepted in every state.
  - Entries are read only in LOAD. A write to the active entry takes effect at that entry's next LOAD.
- States:
  - IDLE: wait for an arm.
  - LOAD: 2 cycles. Latch table[O_index] into O_trigger_delay and O_trigger_width. The second cycle gives the generator's single-stage input sync time to settle.
  - WAIT_MATCH: forward matches to the generator.
  - FIRING: trigger in progress.
  - NEXT: advance to the next entry or finish.
  - DONE: signal completion.
- Transitions:
  - IDLE -> LOAD on I_arm when 1 <= I_num_triggers <= pNUM_TRIGGERS. Set O_index=0 and clear O_timeout.
  - I_arm with I_num_triggers out of range is ignored.
  - LOAD -> WAIT_MATCH after 2 cycles.
  - WAIT_MATCH -> FIRING on a rising edge of I_trigger. Edge detection uses a registered copy of I_trigger.
  - FIRING -> NEXT on a falling edge of I_trigger.
  - NEXT -> DONE if O_index == I_num_triggers-1. Otherwise O_index++ and go to LOAD.
  - DONE -> IDLE after 1 cycle; O_done is high during DONE.
- O_match = I_match_pulse AND (state == WAIT_MATCH). This is combinational with zero latency. Matches in any other state are dropped.
- I_disarm in any state:
  - Go to IDLE next cycle; O_match is forced low the same cycle.
  - O_index, O_trigger_delay and O_trigger_width hold their values.
  - A trigger already running in the generator completes on its own.
  - O_done does not pulse.
- I_arm while armed is ignored. I_arm together with I_disarm: disarm wins.
- I_num_triggers is sampled continuously. It must be held static while armed.

## Timing
- Reset values: O_match=0, O_trigger_delay=0, O_trigger_width=0, O_armed=0, O_done=0, O_index=0, O_timeout=0; state=IDLE.
- Arm to first match acceptance: I_arm at cycle 0, LOAD in cycles 1-2, WAIT_MATCH from cycle 3.
- Trigger falling edge (cycle n) to the next entry's WAIT_MATCH: NEXT at n+1, LOAD at n+2..n+3, WAIT_MATCH at n+4.
- Final trigger falling edge (cycle n) to completion: NEXT at n+1, O_done at n+2, O_armed low from n+3.
- reset_n asserted mid-sequence: all outputs return to reset values immediately (asynchronously).

## Configuration
- PW_TRIG_SEQ_TIMEOUT_EN defined:
  - A watchdog counter clears on entry to WAIT_MATCH and increments each cycle while in WAIT_MATCH.
  - When the count reaches I_timeout (nonzero), set O_timeout and go to IDLE without O_done.
  - I_timeout=0 disables the watchdog.
- PW_TRIG_SEQ_TIMEOUT_EN undefined: no counter; O_timeout is tied to 0; I_timeout is unused.

## Test plan
- Single trigger: write entry 0 = (delay 5, width 3), num=1, arm, match at cycle 10 -> O_match pulses at cycle 10; O_done pulses 2 cycles after I_trigger falls; O_armed goes low.
- Three-entry sequence: entries (2,1), (7,4), (0,2), num=3, one match per WAIT_MATCH -> the delay/width outputs step through the three pairs, O_index goes 0,1,2, exactly one O_done.
- Gating: match during LOAD and during FIRING -> O_match stays 0; only matches in WAIT_MATCH are forwarded.
- Abort: I_disarm during FIRING of entry 1 of 3 -> IDLE next cycle, no O_done, O_index stays 1; a following arm restarts at index 0.
- Illegal arm: num=0 or num=9 -> state stays IDLE, O_armed=0; arm+disarm in the same cycle -> stays IDLE.
- With PW_TRIG_SEQ_TIMEOUT_EN: I_timeout=100, no match -> O_timeout=1 after 100 cycles in WAIT_MATCH, state IDLE, no O_done; the next legal arm clears O_timeout.

Source files
------------

// File: rtl/pw_trigger_sequencer.sv
// Steps a trigger generator through a programmable table of delay/width pairs and gates which match pulses fire a trigger.
// Latency: O_match is combinational (zero cycles); arm->WAIT_MATCH 3 cycles; trigger fall->next WAIT_MATCH 4 cycles, ->O_done 2 cycles.
// Backpressure: none; matches outside WAIT_MATCH are dropped, arm while armed is ignored, disarm aborts from any state.
//
// Optional feature macro: PW_TRIG_SEQ_TIMEOUT_EN enables the WAIT_MATCH watchdog (O_timeout, I_timeout).
//
// Ports:
//   trigger_clk, reset_n                   clock, async active-low reset
//   I_wr_en/I_wr_addr/I_wr_delay/I_wr_width table write port (accepted in any state)
//   I_num_triggers                         sequence length, 1..pNUM_TRIGGERS, static while armed
//   I_arm / I_disarm                       single-cycle start / abort (disarm wins)
//   I_match_pulse, I_trigger               synchronized match pulse, generator trigger-active level
//   I_timeout                              watchdog limit in cycles (0 = off)
//   O_match                                gated match to the generator
//   O_trigger_delay/O_trigger_width        current entry presented to the generator
//   O_armed, O_done, O_index, O_timeout    sequence status
module pw_trigger_sequencer #(
   parameter int pTRIGGER_DELAY_WIDTH = 20,
   parameter int pTRIGGER_WIDTH_WIDTH = 17,
   parameter int pNUM_TRIGGERS        = 8,
   parameter int pINDEX_WIDTH         = 3,
   parameter int pTIMEOUT_WIDTH       = 24
) (
   input  logic                            trigger_clk,
   input  logic                            reset_n,
   input  logic                            I_wr_en,
   input  logic [pINDEX_WIDTH-1:0]         I_wr_addr,
   input  logic [pTRIGGER_DELAY_WIDTH-1:0] I_wr_delay,
   input  logic [pTRIGGER_WIDTH_WIDTH-1:0] I_wr_width,
   input  logic [pINDEX_WIDTH:0]           I_num_triggers,
   input  logic                            I_arm,
   input  logic                            I_disarm,
   input  logic                            I_match_pulse,
   input  logic                            I_trigger,
   input  logic [pTIMEOUT_WIDTH-1:0]       I_timeout,
   output logic                            O_match,
   output logic [pTRIGGER_DELAY_WIDTH-1:0] O_trigger_delay,
   output logic [pTRIGGER_WIDTH_WIDTH-1:0] O_trigger_width,
   output logic                            O_armed,
   output logic                            O_done,
   output logic [pINDEX_WIDTH-1:0]         O_index,
   output logic                            O_timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT_MATCH, S_FIRING, S_NEXT, S_DONE
   } state_t;

   localparam logic [pINDEX_WIDTH:0] LP_MAX_NUM = (pINDEX_WIDTH+1)'(pNUM_TRIGGERS);

   state_t                            r_state;
   state_t                            w_next_state;
   logic                              r_load_cnt;
   logic                              r_trig_d;
   logic [pINDEX_WIDTH-1:0]           r_index;
   logic [pTRIGGER_DELAY_WIDTH-1:0]   r_delay;
   logic [pTRIGGER_WIDTH_WIDTH-1:0]   r_width;
   logic [pTRIGGER_DELAY_WIDTH-1:0]   r_delay_tbl [pNUM_TRIGGERS];
   logic [pTRIGGER_WIDTH_WIDTH-1:0]   r_width_tbl [pNUM_TRIGGERS];

   logic                              w_arm_ok;
   logic                              w_rise;
   logic                              w_fall;
   logic                              w_last;
   logic                              w_wd_hit;
   logic [pINDEX_WIDTH:0]             w_last_idx;

   // Arm+disarm in the same cycle must not touch index/timeout, so disarm is folded in here.
   assign w_arm_ok   = I_arm && !I_disarm && (r_state == S_IDLE) &&
                       (I_num_triggers != '0) && (I_num_triggers <= LP_MAX_NUM);
   assign w_rise     = I_trigger && !r_trig_d;
   assign w_fall     = !I_trigger && r_trig_d;
   assign w_last_idx = I_num_triggers - 1'b1;
   assign w_last     = ({1'b0, r_index} == w_last_idx);

`ifdef PW_TRIG_SEQ_TIMEOUT_EN
   logic [pTIMEOUT_WIDTH-1:0] r_wd_cnt;
   logic [pTIMEOUT_WIDTH-1:0] w_wd_cnt_inc;
   logic                      r_timeout;

   assign w_wd_cnt_inc = r_wd_cnt + 1'b1;
   // Fires on the I_timeout-th cycle spent in WAIT_MATCH; the flag is visible the cycle after.
   assign w_wd_hit     = (r_state == S_WAIT_MATCH) && (I_timeout != '0) && (w_wd_cnt_inc == I_timeout);

   always_ff @(posedge trigger_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         // Held at zero outside WAIT_MATCH, so every entry into WAIT_MATCH starts a fresh count.
         r_wd_cnt <= (r_state == S_WAIT_MATCH) ? w_wd_cnt_inc : '0;
         if (w_arm_ok)
            r_timeout <= 1'b0;
         else if (w_wd_hit && !w_rise && !I_disarm)
            r_timeout <= 1'b1;
      end
   end

   assign O_timeout = r_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^I_timeout;
   assign w_wd_hit         = 1'b0;
   assign O_timeout        = 1'b0;
`endif

   always_ff @(posedge trigger_clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:       if (w_arm_ok) w_next_state = S_LOAD;
         S_LOAD:       if (r_load_cnt) w_next_state = S_WAIT_MATCH;
         S_WAIT_MATCH: begin
            if (w_rise)        w_next_state = S_FIRING;
            else if (w_wd_hit) w_next_state = S_IDLE;
         end
         S_FIRING:     if (w_fall) w_next_state = S_NEXT;
         S_NEXT:       w_next_state = w_last ? S_DONE : S_LOAD;
         S_DONE:       w_next_state = S_IDLE;
         default:      w_next_state = S_IDLE;
      endcase
      if (I_disarm) w_next_state = S_IDLE;
   end

   always_ff @(posedge trigger_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_load_cnt <= 1'b0;
         r_trig_d   <= 1'b0;
         r_index    <= '0;
         r_delay    <= '0;
         r_width    <= '0;
      end else begin
         r_trig_d <= I_trigger;
         // Toggles 0->1 across the two LOAD cycles; zero in every other state.
         r_load_cnt <= (r_state == S_LOAD) ? !r_load_cnt : 1'b0;
         if (w_arm_ok)
            r_index <= '0;
         else if ((r_state == S_NEXT) && !w_last && !I_disarm)
            r_index <= r_index + 1'b1;
         // Table is read only here, so a write to the active entry lands at its next LOAD.
         if ((r_state == S_LOAD) && !I_disarm) begin
            r_delay <= r_delay_tbl[r_index];
            r_width <= r_width_tbl[r_index];
         end
      end
   end

   always_ff @(posedge trigger_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < pNUM_TRIGGERS; i++) begin
            r_delay_tbl[i] <= '0;
            r_width_tbl[i] <= '0;
         end
      end else if (I_wr_en) begin
         r_delay_tbl[I_wr_addr] <= I_wr_delay;
         r_width_tbl[I_wr_addr] <= I_wr_width;
      end
   end

   assign O_match         = I_match_pulse && (r_state == S_WAIT_MATCH) && !I_disarm;
   assign O_trigger_delay = r_delay;
   assign O_trigger_width = r_width;
   assign O_armed         = (r_state != S_IDLE);
   assign O_done          = (r_state == S_DONE);
   assign O_index         = r_index;

endmodule
